img_op_sequencer: RTL and testbench

- Parametrised next-generation command sequencer for the image convolution core.
- Decodes host opcodes and holds the geometry and sigma registers.
- Starts and monitors the RX, TX and row-convolution engines through start/busy handshakes, and drives the SRAM port-mux selects.
- Adds over the previous top: a programmable number of convolution passes, abort, sticky error reporting, a status readback and dout_valid.

---
 rtl/img_op_sequencer_if.sv | 16 +
 rtl/img_op_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_img_op_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/img_op_sequencer_if.sv
// Host command bus of the image-op sequencer: opcode strobe and write data in,
// read data, read strobe and status flags out.
interface img_op_sequencer_if #(
  parameter int DW = 8
);
  logic          en;
  logic [3:0]    op;
  logic [DW-1:0] din;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          err;

  modport master (output en, op, din, input dout, dout_valid, busy, err);
  modport slave  (input en, op, din, output dout, dout_valid, busy, err);
endinterface

// File: rtl/img_op_sequencer.sv
// Command sequencer for the image convolution core: decodes host opcodes, holds
// geometry/sigma/pass registers and sequences the RX, TX and multi-pass CONV engines.
module img_op_sequencer #(
  parameter int DW      = 8,
  parameter int DIMW    = 8,
  parameter int SIGW    = 3,
  parameter int PASS_W  = 3,
  parameter int RST_DIM = 8
) (
  input  logic               clk,
  input  logic               rstn,
  img_op_sequencer_if.slave  host,
  output logic [DIMW-1:0]    nrows,
  output logic [DIMW-1:0]    ncols,
  output logic [SIGW-1:0]    sigma,
  output logic               rx_start,
  output logic               tx_start,
  output logic               conv_start,
  input  logic               rx_busy,
  input  logic               tx_busy,
  input  logic               conv_busy,
  output logic               eng_abort,
  output logic               conv_swap,
  output logic [DIMW-1:0]    conv_nrows,
  output logic [DIMW-1:0]    conv_ncols,
  output logic [2:0]         img_sel,
  output logic [2:0]         buf_sel
);

  localparam logic [3:0] OP_GET_NROWS  = 4'd1;
  localparam logic [3:0] OP_GET_NCOLS  = 4'd2;
  localparam logic [3:0] OP_GET_SIGMA  = 4'd3;
  localparam logic [3:0] OP_SET_NROWS  = 4'd4;
  localparam logic [3:0] OP_SET_NCOLS  = 4'd5;
  localparam logic [3:0] OP_SET_SIGMA  = 4'd6;
  localparam logic [3:0] OP_IMG_RX     = 4'd7;
  localparam logic [3:0] OP_IMG_TX     = 4'd8;
  localparam logic [3:0] OP_CONV       = 4'd9;
  localparam logic [3:0] OP_SET_PASSES = 4'd10;
  localparam logic [3:0] OP_GET_STATUS = 4'd11;
  localparam logic [3:0] OP_ABORT      = 4'd12;
  localparam logic [3:0] OP_NOP        = 4'd0;

  localparam logic [2:0] SEL_HOLD     = 3'd0;
  localparam logic [2:0] SEL_RX       = 3'd1;
  localparam logic [2:0] SEL_TX       = 3'd2;
  localparam logic [2:0] SEL_CONV_IMG = 3'd3;
  localparam logic [2:0] SEL_CONV_BUF = 3'd4;

  localparam logic [DIMW-1:0]   RST_DIM_V  = DIMW'(RST_DIM);
  localparam logic [PASS_W-1:0] PASS_ONE   = PASS_W'(1);
  localparam logic [PASS_W-1:0] PASS_RESET = PASS_W'(2);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RX_START   = 3'd1,
    RX_RUN     = 3'd2,
    TX_START   = 3'd3,
    TX_RUN     = 3'd4,
    CONV_START = 3'd5,
    CONV_RUN   = 3'd6,
    CONV_GAP   = 3'd7
  } state_t;

  state_t            state_r;
  logic [DW-1:0]     dout_r;
  logic              dout_valid_r, busy_r, err_r, res_in_buf_r;
  logic [DIMW-1:0]   nrows_r, ncols_r;
  logic [SIGW-1:0]   sigma_r;
  logic [PASS_W-1:0] passes_r, pass_idx_r;
  logic              rx_start_r, tx_start_r, conv_start_r, eng_abort_r, conv_swap_r;
  logic [2:0]        img_sel_s, buf_sel_s;
  logic              dims_zero_s;

  function automatic logic [DW-1:0] zext_dim(input logic [DIMW-1:0] v);
    logic [DW-1:0] w;
    w = {DW{1'b0}};
    w[DIMW-1:0] = v;
    return w;
  endfunction

  function automatic logic [DW-1:0] zext_sig(input logic [SIGW-1:0] v);
    logic [DW-1:0] w;
    w = {DW{1'b0}};
    w[SIGW-1:0] = v;
    return w;
  endfunction

  function automatic logic [DW-1:0] status_word(input logic e, input logic r, input logic b);
    logic [DW-1:0] w;
    w = {DW{1'b0}};
    w[3:0] = {e, r, b, 1'b0};
    return w;
  endfunction

  assign dims_zero_s = (nrows_r == {DIMW{1'b0}}) || (ncols_r == {DIMW{1'b0}});

  // Sequencer FSM with all host, register and engine-handshake outputs registered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      dout_r       <= {DW{1'b0}};
      dout_valid_r <= 1'b0;
      busy_r       <= 1'b0;
      err_r        <= 1'b0;
      res_in_buf_r <= 1'b0;
      nrows_r      <= RST_DIM_V;
      ncols_r      <= RST_DIM_V;
      sigma_r      <= {SIGW{1'b0}};
      passes_r     <= PASS_RESET;
      pass_idx_r   <= {PASS_W{1'b0}};
      rx_start_r   <= 1'b0;
      tx_start_r   <= 1'b0;
      conv_start_r <= 1'b0;
      eng_abort_r  <= 1'b0;
      conv_swap_r  <= 1'b0;
    end else begin
      dout_valid_r <= 1'b0;
      rx_start_r   <= 1'b0;
      tx_start_r   <= 1'b0;
      conv_start_r <= 1'b0;
      eng_abort_r  <= 1'b0;
      if (state_r == IDLE) begin
        if (host.en) begin
          case (host.op)
            OP_GET_NROWS: begin dout_r <= zext_dim(nrows_r); dout_valid_r <= 1'b1; end
            OP_GET_NCOLS: begin dout_r <= zext_dim(ncols_r); dout_valid_r <= 1'b1; end
            OP_GET_SIGMA: begin dout_r <= zext_sig(sigma_r); dout_valid_r <= 1'b1; end
            OP_GET_STATUS: begin
              dout_r       <= status_word(err_r, res_in_buf_r, busy_r);
              dout_valid_r <= 1'b1;
              err_r        <= 1'b0;
            end
            OP_SET_NROWS: nrows_r <= host.din[DIMW-1:0];
            OP_SET_NCOLS: ncols_r <= host.din[DIMW-1:0];
            OP_SET_SIGMA: sigma_r <= host.din[SIGW-1:0];
            OP_SET_PASSES: begin
              if (host.din[PASS_W-1:0] == {PASS_W{1'b0}}) err_r <= 1'b1;
              else passes_r <= host.din[PASS_W-1:0];
            end
            OP_IMG_RX, OP_IMG_TX, OP_CONV: begin
              if (dims_zero_s) begin
                err_r <= 1'b1;
              end else begin
                busy_r <= 1'b1;
                case (host.op)
                  OP_IMG_RX: begin state_r <= RX_START; rx_start_r <= 1'b1; end
                  OP_IMG_TX: begin state_r <= TX_START; tx_start_r <= 1'b1; end
                  default: begin
                    state_r      <= CONV_START;
                    conv_start_r <= 1'b1;
                    pass_idx_r   <= {PASS_W{1'b0}};
                    conv_swap_r  <= 1'b0;
                  end
                endcase
              end
            end
            default: begin end
          endcase
        end
      end else if (host.en && (host.op == OP_ABORT)) begin
        // Abort wins over any engine completion seen on the same edge
        eng_abort_r <= 1'b1;
        state_r     <= IDLE;
        busy_r      <= 1'b0;
        conv_swap_r <= 1'b0;
      end else begin
        if (host.en && (host.op != OP_NOP)) err_r <= 1'b1;
        case (state_r)
          RX_START:   state_r <= RX_RUN;
          TX_START:   state_r <= TX_RUN;
          CONV_START: state_r <= CONV_RUN;
          RX_RUN: begin
            if (!rx_busy) begin state_r <= IDLE; busy_r <= 1'b0; end
          end
          TX_RUN: begin
            if (!tx_busy) begin state_r <= IDLE; busy_r <= 1'b0; end
          end
          CONV_RUN: begin
            if (!conv_busy) begin
              if (pass_idx_r == (passes_r - PASS_ONE)) begin
                res_in_buf_r <= passes_r[0];
                state_r      <= IDLE;
                busy_r       <= 1'b0;
                conv_swap_r  <= 1'b0;
              end else begin
                pass_idx_r <= pass_idx_r + PASS_ONE;
                state_r    <= CONV_GAP;
              end
            end
          end
          CONV_GAP: begin
            conv_swap_r  <= pass_idx_r[0];
            conv_start_r <= 1'b1;
            state_r      <= CONV_START;
          end
          default: begin state_r <= IDLE; busy_r <= 1'b0; end
        endcase
      end
    end
  end

  // SRAM mux selects decoded from the registered state and pass direction
  always_comb begin
    img_sel_s = SEL_HOLD;
    buf_sel_s = SEL_HOLD;
    case (state_r)
      RX_START, RX_RUN: img_sel_s = SEL_RX;
      TX_START, TX_RUN: img_sel_s = SEL_TX;
      CONV_START, CONV_RUN, CONV_GAP: begin
        img_sel_s = conv_swap_r ? SEL_CONV_BUF : SEL_CONV_IMG;
        buf_sel_s = conv_swap_r ? SEL_CONV_IMG : SEL_CONV_BUF;
      end
      default: begin
        img_sel_s = SEL_HOLD;
        buf_sel_s = SEL_HOLD;
      end
    endcase
  end

  assign host.dout       = dout_r;
  assign host.dout_valid = dout_valid_r;
  assign host.busy       = busy_r;
  assign host.err        = err_r;
  assign nrows           = nrows_r;
  assign ncols           = ncols_r;
  assign sigma           = sigma_r;
  assign rx_start        = rx_start_r;
  assign tx_start        = tx_start_r;
  assign conv_start      = conv_start_r;
  assign eng_abort       = eng_abort_r;
  assign conv_swap       = conv_swap_r;
  assign conv_nrows      = conv_swap_r ? ncols_r : nrows_r;
  assign conv_ncols      = conv_swap_r ? nrows_r : ncols_r;
  assign img_sel         = img_sel_s;
  assign buf_sel         = buf_sel_s;

endmodule

// File: tb/tb_img_op_sequencer.sv
// Randomized self-checking bench for img_op_sequencer: engine models with programmable
// busy length, and a transaction-level model of the host-visible registers and flags.
module tb_img_op_sequencer;
  localparam int DW = 8, DIMW = 8, SIGW = 3, PASS_W = 3;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  img_op_sequencer_if #(.DW(DW)) hif ();
  logic [DIMW-1:0] nrows, ncols, conv_nrows, conv_ncols;
  logic [SIGW-1:0] sigma;
  logic rx_start, tx_start, conv_start, eng_abort, conv_swap;
  logic rx_busy, tx_busy, conv_busy;
  logic [2:0] img_sel, buf_sel;

  img_op_sequencer #(.DW(DW), .DIMW(DIMW), .SIGW(SIGW), .PASS_W(PASS_W), .RST_DIM(8)) dut (
    .clk(clk), .rstn(rstn), .host(hif),
    .nrows(nrows), .ncols(ncols), .sigma(sigma),
    .rx_start(rx_start), .tx_start(tx_start), .conv_start(conv_start),
    .rx_busy(rx_busy), .tx_busy(tx_busy), .conv_busy(conv_busy),
    .eng_abort(eng_abort), .conv_swap(conv_swap),
    .conv_nrows(conv_nrows), .conv_ncols(conv_ncols),
    .img_sel(img_sel), .buf_sel(buf_sel)
  );

  // Engines: busy for eng_len cycles starting the cycle after their start pulse
  int eng_len = 1;
  int rx_cnt, tx_cnt, cv_cnt;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_cnt <= 0; tx_cnt <= 0; cv_cnt <= 0;
    end else if (eng_abort) begin
      rx_cnt <= 0; tx_cnt <= 0; cv_cnt <= 0;
    end else begin
      rx_cnt <= rx_start ? eng_len : (rx_cnt > 0 ? rx_cnt - 1 : 0);
      tx_cnt <= tx_start ? eng_len : (tx_cnt > 0 ? tx_cnt - 1 : 0);
      cv_cnt <= conv_start ? eng_len : (cv_cnt > 0 ? cv_cnt - 1 : 0);
    end
  end
  assign rx_busy   = (rx_cnt != 0);
  assign tx_busy   = (tx_cnt != 0);
  assign conv_busy = (cv_cnt != 0);

  // Event counters and per-pass snapshots taken at every conv_start pulse
  int n_rx = 0, n_tx = 0, n_cv = 0, n_ab = 0, n_busy = 0, n_sel_rx = 0, n_sel_tx = 0;
  int q_swap[$], q_cnr[$], q_img[$], q_buf[$];
  always @(negedge clk) begin
    if (rstn) begin
      if (rx_start)  n_rx <= n_rx + 1;
      if (tx_start)  n_tx <= n_tx + 1;
      if (eng_abort) n_ab <= n_ab + 1;
      if (hif.busy)  n_busy <= n_busy + 1;
      if (hif.busy && img_sel == 3'd1 && buf_sel == 3'd0) n_sel_rx <= n_sel_rx + 1;
      if (hif.busy && img_sel == 3'd2 && buf_sel == 3'd0) n_sel_tx <= n_sel_tx + 1;
      if (conv_start) begin
        n_cv <= n_cv + 1;
        q_swap.push_back(int'(conv_swap));
        q_cnr.push_back(int'(conv_nrows));
        q_img.push_back(int'(img_sel));
        q_buf.push_back(int'(buf_sel));
      end
    end
  end

  int n_chk = 0, n_pass = 0;
  int m_nrows, m_ncols, m_sigma, m_passes, m_err, m_res;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_nrows = 8; m_ncols = 8; m_sigma = 0; m_passes = 2; m_err = 0; m_res = 0;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_busy"}, int'(hif.busy), 0);
    chk({pfx, "_err"}, int'(hif.err), 0);
    chk({pfx, "_dout"}, int'(hif.dout), 0);
    chk({pfx, "_dvalid"}, int'(hif.dout_valid), 0);
    chk({pfx, "_starts"}, int'({rx_start, tx_start, conv_start, eng_abort}), 0);
    chk({pfx, "_swap"}, int'(conv_swap), 0);
    chk({pfx, "_nrows"}, int'(nrows), 8);
    chk({pfx, "_ncols"}, int'(ncols), 8);
    chk({pfx, "_sigma"}, int'(sigma), 0);
    chk({pfx, "_sel"}, int'({img_sel, buf_sel}), 0);
  endtask

  // Present one opcode for a single cycle; returns at the negedge after it was sampled
  task automatic issue(input int op, input int din);
    hif.en = 1'b1; hif.op = 4'(op); hif.din = DW'(din);
    @(negedge clk);
    hif.en = 1'b0; hif.op = 4'd0; hif.din = '0;
  endtask

  function automatic int rand_illegal();
    int v;
    v = $urandom_range(1, 14);
    if (v >= 12) v++;
    return v;
  endfunction

  // One host transaction; mid: 0 none, 1 illegal op while busy, 2 abort, 3 illegal then abort
  task automatic run_op(input int op, input int din, input int len, input int mid, input int mid_op);
    int b_rx, b_tx, b_cv, b_ab, b_busy, b_srx, b_stx, b_q, guard, at, p, exp_dout;
    bit aborted;
    eng_len = len;
    b_rx = n_rx; b_tx = n_tx; b_cv = n_cv; b_ab = n_ab; b_busy = n_busy;
    b_srx = n_sel_rx; b_stx = n_sel_tx; b_q = q_swap.size();
    if ((op == 7 || op == 8 || op == 9) && m_nrows != 0 && m_ncols != 0) begin
      p = m_passes;
      aborted = 1'b0;
      at = $urandom_range(0, len - 1);
      guard = 0;
      issue(op, din);
      while (hif.busy && guard < 2000) begin
        if (mid != 0 && guard == at) begin
          if (mid == 1 || mid == 3) begin
            issue(mid_op, $urandom_range(0, 255));
            m_err = 1;
            guard++;
          end
          if (mid >= 2) begin
            issue(12, 0);
            aborted = 1'b1;
            chk("abort_pulse", int'(eng_abort), 1);
            chk("abort_busy", int'(hif.busy), 0);
            chk("abort_swap", int'(conv_swap), 0);
          end
        end else begin
          @(negedge clk);
          guard++;
        end
      end
      if (guard >= 2000) chk("busy_timeout", 1, 0);
      // Each pass: start cycle + len engine-busy cycles + done-detect cycle; one gap cycle between passes
      if (!aborted) begin
        if (op == 7) begin
          chk("rx_starts", n_rx - b_rx, 1);
          chk("rx_busy_cycles", n_busy - b_busy, len + 2);
          chk("rx_img_sel", n_sel_rx - b_srx, len + 2);
        end else if (op == 8) begin
          chk("tx_starts", n_tx - b_tx, 1);
          chk("tx_busy_cycles", n_busy - b_busy, len + 2);
          chk("tx_img_sel", n_sel_tx - b_stx, len + 2);
        end else begin
          chk("conv_starts", n_cv - b_cv, p);
          chk("conv_busy_cycles", n_busy - b_busy, p * (len + 3) - 1);
          for (int i = 0; i < p && (b_q + i) < q_swap.size(); i++) begin
            chk("conv_swap_seq", q_swap[b_q + i], i % 2);
            chk("conv_nrows_seq", q_cnr[b_q + i], (i % 2) ? m_ncols : m_nrows);
            chk("img_sel_seq", q_img[b_q + i], (i % 2) ? 4 : 3);
            chk("buf_sel_seq", q_buf[b_q + i], (i % 2) ? 3 : 4);
          end
          m_res = p % 2;
        end
        chk("swap_after", int'(conv_swap), 0);
      end
      repeat (3) @(negedge clk);
      chk("abort_count", n_ab - b_ab, aborted ? 1 : 0);
    end else begin
      exp_dout = -1;
      case (op)
        1: exp_dout = m_nrows;
        2: exp_dout = m_ncols;
        3: exp_dout = m_sigma;
        11: exp_dout = m_err * 8 + m_res * 4;
        4: m_nrows = din & 255;
        5: m_ncols = din & 255;
        6: m_sigma = din & 7;
        10: if ((din & 7) == 0) m_err = 1; else m_passes = din & 7;
        7, 8, 9: m_err = 1;
        default: begin end
      endcase
      if (op == 11) m_err = 0;
      issue(op, din);
      chk("short_busy", int'(hif.busy), 0);
      if (exp_dout >= 0) begin
        chk("get_dout", int'(hif.dout), exp_dout);
        chk("get_dvalid", int'(hif.dout_valid), 1);
      end else begin
        chk("dvalid_idle", int'(hif.dout_valid), 0);
      end
      repeat (2) @(negedge clk);
      chk("dvalid_drop", int'(hif.dout_valid), 0);
      chk("no_start", (n_rx - b_rx) + (n_tx - b_tx) + (n_cv - b_cv), 0);
    end
    chk("reg_nrows", int'(nrows), m_nrows);
    chk("reg_ncols", int'(ncols), m_ncols);
    chk("reg_sigma", int'(sigma), m_sigma);
    chk("err_flag", int'(hif.err), m_err);
  endtask

  initial begin
    int b_cv, guard, op, din, mid;
    hif.en = 1'b0; hif.op = 4'd0; hif.din = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    run_op(1, 0, 1, 0, 0);
    run_op(3, 0, 1, 0, 0);
    run_op(4, 5, 1, 0, 0);
    run_op(5, 3, 1, 0, 0);
    run_op(7, 0, 15, 0, 0);
    run_op(10, 3, 1, 0, 0);
    run_op(9, 0, 4, 0, 0);
    run_op(11, 0, 1, 0, 0);
    run_op(8, 0, 10, 3, 6);
    run_op(11, 0, 1, 0, 0);
    run_op(5, 0, 1, 0, 0);
    run_op(9, 0, 3, 0, 0);
    run_op(11, 0, 1, 0, 0);
    run_op(10, 8, 1, 0, 0);
    run_op(5, 3, 1, 0, 0);
    run_op(9, 0, 2, 0, 0);

    // Reset pulled during the second conv pass
    eng_len = 6;
    b_cv = n_cv;
    issue(9, 0);
    guard = 0;
    while ((n_cv - b_cv) < 2 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 500) chk("pass2_timeout", 1, 0);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_reset_outputs("midreset");
    @(negedge clk);
    rstn = 1'b1;
    b_cv = n_cv;
    repeat (20) @(negedge clk);
    chk("post_reset_starts", n_cv - b_cv, 0);
    model_reset();

    for (int k = 0; k < 80; k++) begin
      op  = $urandom_range(0, 15);
      din = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 255);
      mid = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      run_op(op, din, $urandom_range(1, 8), mid, rand_illegal());
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
